// File: rtl/register_file.sv
// Register file: one synchronous write port and two combinational read ports.
// Optional write-to-read forwarding is enabled with the REGFILE_BYPASS_EN macro.

module register_we #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_en,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);
    logic [WIDTH-1:0] r_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_q <= '0;
        end else if (i_en) begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;
endmodule

module register_file #(
    parameter int WIDTH   = 8,
    parameter int ADDR_W  = 3,
    parameter bit ZERO_R0 = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              WE,
    input  logic [ADDR_W-1:0] WA,
    input  logic [WIDTH-1:0]  WD,
    input  logic [ADDR_W-1:0] RA1,
    input  logic [ADDR_W-1:0] RA2,
    output logic [WIDTH-1:0]  RD1,
    output logic [WIDTH-1:0]  RD2
);
    localparam int NREG = 2 ** ADDR_W;

    logic [NREG-1:0]  w_we;
    logic [WIDTH-1:0] w_q [NREG];
    logic [WIDTH-1:0] w_rd1_stored;
    logic [WIDTH-1:0] w_rd2_stored;
    logic             w_ra1_zero;
    logic             w_ra2_zero;

    // One-hot decode gated by WE, so an unknown WA with WE low enables nothing.
    for (genvar i = 0; i < NREG; i++) begin : g_entry
        if (i == 0 && ZERO_R0) begin : g_r0_fixed
            assign w_we[i] = 1'b0;
        end else begin : g_r_normal
            assign w_we[i] = WE && (WA == ADDR_W'(i));
        end

        register_we #(.WIDTH(WIDTH)) u_reg (
            .clk   (clk),
            .reset (reset),
            .i_en  (w_we[i]),
            .i_d   (WD),
            .o_q   (w_q[i])
        );
    end

    // Entry 0 is masked on read as well so it is zero even before the first reset.
    assign w_ra1_zero   = ZERO_R0 && (RA1 == '0);
    assign w_ra2_zero   = ZERO_R0 && (RA2 == '0);
    assign w_rd1_stored = w_ra1_zero ? '0 : w_q[RA1];
    assign w_rd2_stored = w_ra2_zero ? '0 : w_q[RA2];

`ifdef REGFILE_BYPASS_EN
    logic w_fwd1;
    logic w_fwd2;

    assign w_fwd1 = WE && !reset && (WA == RA1) && !w_ra1_zero;
    assign w_fwd2 = WE && !reset && (WA == RA2) && !w_ra2_zero;
    assign RD1    = w_fwd1 ? WD : w_rd1_stored;
    assign RD2    = w_fwd2 ? WD : w_rd2_stored;
`else
    assign RD1 = w_rd1_stored;
    assign RD2 = w_rd2_stored;
`endif
endmodule

// File: tb/tb_register_file.sv
// Directed bench for register_file: one instance with hardwired R0, one with an
// ordinary R0, both on shared inputs.

module tb_register_file;
    logic       clk = 1'b0;
    logic       reset;
    logic       WE;
    logic [2:0] WA;
    logic [7:0] WD;
    logic [2:0] RA1;
    logic [2:0] RA2;
    logic [7:0] rd1, rd2, rd1_nz, rd2_nz;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    register_file #(.WIDTH(8), .ADDR_W(3), .ZERO_R0(1'b1)) dut (
        .clk(clk), .reset(reset), .WE(WE), .WA(WA), .WD(WD),
        .RA1(RA1), .RA2(RA2), .RD1(rd1), .RD2(rd2)
    );

    register_file #(.WIDTH(8), .ADDR_W(3), .ZERO_R0(1'b0)) dut_nz (
        .clk(clk), .reset(reset), .WE(WE), .WA(WA), .WD(WD),
        .RA1(RA1), .RA2(RA2), .RD1(rd1_nz), .RD2(rd2_nz)
    );

    task automatic wait_after_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic write_entry(input logic [2:0] addr, input logic [7:0] data);
        @(negedge clk);
        WE = 1'b1; WA = addr; WD = data;
        wait_after_edge();
        @(negedge clk);
        WE = 1'b0;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 8; i++) write_entry(3'(i), 8'(8'h10 + i));
        @(negedge clk);
        RA1 = 3'd4; #1;
        n_total++;
        if (rd1_nz !== 8'h14) $display("FAIL pre_reset_write got %h exp %h", rd1_nz, 8'h14);
        else n_pass++;
        @(negedge clk);
        reset = 1'b1;
        wait_after_edge();
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            RA1 = 3'(i); RA2 = 3'(7 - i); #1;
            n_total++;
            if (rd1 !== 8'h00 || rd2 !== 8'h00 || rd1_nz !== 8'h00 || rd2_nz !== 8'h00)
                $display("FAIL reset_clear ra=%0d got %h %h %h %h exp 00", i, rd1, rd2, rd1_nz, rd2_nz);
            else n_pass++;
        end
    endtask

    task automatic test_write();
        write_entry(3'd3, 8'hA5);
        RA1 = 3'd3; RA2 = 3'd3; #1;
        n_total++;
        if (rd1 !== 8'hA5 || rd2 !== 8'hA5) $display("FAIL write_same_ra got %h %h exp a5", rd1, rd2);
        else n_pass++;
        for (int i = 1; i < 8; i++) begin
            if (i != 3) begin
                RA1 = 3'(i); #1;
                n_total++;
                if (rd1 !== 8'h00) $display("FAIL write_others ra=%0d got %h exp 00", i, rd1);
                else n_pass++;
            end
        end
    endtask

    task automatic test_we_low();
        @(negedge clk);
        WE = 1'b0; WA = 3'd3; WD = 8'hFF; RA1 = 3'd3;
        wait_after_edge();
        n_total++;
        if (rd1 !== 8'hA5) $display("FAIL we_low_hold got %h exp a5", rd1);
        else n_pass++;
        @(negedge clk);
        WA = 3'bxxx; WD = 8'h77;
        wait_after_edge();
        for (int i = 0; i < 8; i++) begin
            RA1 = 3'(i); #1;
            n_total++;
            if (rd1_nz !== ((i == 3) ? 8'hA5 : 8'h00))
                $display("FAIL we_low_xaddr ra=%0d got %h exp %h", i, rd1_nz, (i == 3) ? 8'hA5 : 8'h00);
            else n_pass++;
        end
    endtask

    task automatic test_zero_r0();
        write_entry(3'd0, 8'h5A);
        RA1 = 3'd0; RA2 = 3'd0; #1;
        n_total++;
        if (rd1 !== 8'h00 || rd2 !== 8'h00) $display("FAIL zero_r0_hard got %h %h exp 00", rd1, rd2);
        else n_pass++;
        n_total++;
        if (rd1_nz !== 8'h5A) $display("FAIL zero_r0_plain got %h exp 5a", rd1_nz);
        else n_pass++;
    endtask

    task automatic test_reset_priority();
        @(negedge clk);
        reset = 1'b1; WE = 1'b1; WA = 3'd5; WD = 8'h3C; RA1 = 3'd5; RA2 = 3'd3;
        wait_after_edge();
        @(negedge clk);
        reset = 1'b0; WE = 1'b0; #1;
        n_total++;
        if (rd1 !== 8'h00 || rd1_nz !== 8'h00) $display("FAIL reset_over_we got %h %h exp 00", rd1, rd1_nz);
        else n_pass++;
        n_total++;
        if (rd2 !== 8'h00) $display("FAIL reset_clears_a5 got %h exp 00", rd2);
        else n_pass++;
    endtask

    task automatic test_reset_midcycle();
        write_entry(3'd2, 8'h99);
        RA1 = 3'd2;
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        n_total++;
        if (rd1 !== 8'h99) $display("FAIL reset_mid_before got %h exp 99", rd1);
        else n_pass++;
        #1 reset = 1'b0;
        wait_after_edge();
        n_total++;
        if (rd1 !== 8'h99) $display("FAIL reset_mid_after got %h exp 99", rd1);
        else n_pass++;
    endtask

    task automatic test_read_during_write();
        logic [7:0] exp_before;
`ifdef REGFILE_BYPASS_EN
        exp_before = 8'hC3;
`else
        exp_before = 8'h00;
`endif
        @(negedge clk);
        WE = 1'b1; WA = 3'd6; WD = 8'hC3; RA1 = 3'd6; RA2 = 3'd2;
        #1;
        n_total++;
        if (rd1 !== exp_before) $display("FAIL rdw_before got %h exp %h", rd1, exp_before);
        else n_pass++;
        n_total++;
        if (rd2 !== 8'h99) $display("FAIL rdw_other_port got %h exp 99", rd2);
        else n_pass++;
        wait_after_edge();
        n_total++;
        if (rd1 !== 8'hC3) $display("FAIL rdw_after got %h exp c3", rd1);
        else n_pass++;
        @(negedge clk);
        WE = 1'b0;
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        WE = 1'b1; WA = 3'd1; WD = 8'h11;
        @(negedge clk);
        WA = 3'd7; WD = 8'hE7;
        @(negedge clk);
        WA = 3'd1; WD = 8'h1F;
        @(negedge clk);
        WE = 1'b0;
        RA1 = 3'd1; RA2 = 3'd7; #1;
        n_total++;
        if (rd1 !== 8'h1F || rd2 !== 8'hE7) $display("FAIL b2b_read got %h %h exp 1f e7", rd1, rd2);
        else n_pass++;
        RA1 = 3'd6; RA2 = 3'd2; #1;
        n_total++;
        if (rd1 !== 8'hC3 || rd2 !== 8'h99) $display("FAIL b2b_hold got %h %h exp c3 99", rd1, rd2);
        else n_pass++;
    endtask

    initial begin
        reset = 1'b1; WE = 1'b0; WA = '0; WD = '0; RA1 = '0; RA2 = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        test_reset();
        test_write();
        test_we_low();
        test_zero_r0();
        test_reset_priority();
        test_reset_midcycle();
        test_read_during_write();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
